reorder_buf: RTL

REORDER_BUF -- requirements
Module: reorder_buf

---
 rtl/reorder_buf.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/reorder_buf.sv
// Reorder buffer: in-order retirement of out-of-order results with CDB capture,
// operand lookup/forwarding and branch-misprediction flush.
module reorder_buf #(
  parameter int ROB_SZ = 16,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             alloc_valid,
  input  logic             alloc_has_rd,
  input  logic [4:0]       alloc_rd,
  input  logic             alloc_is_br,
  input  logic             alloc_pred_taken,
  input  logic [31:0]      alloc_alt_pc,
  output logic [TAG_W-1:0] tail_tag,
  output logic             full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_br_taken,
  input  logic [TAG_W-1:0] q1_tag,
  input  logic [TAG_W-1:0] q2_tag,
  output logic             q1_ready,
  output logic [31:0]      q1_value,
  output logic             q2_ready,
  output logic [31:0]      q2_value,
  output logic             commit_valid,
  output logic [4:0]       commit_rd,
  output logic [31:0]      commit_res,
  output logic [TAG_W-1:0] commit_tag,
  output logic             flush,
  output logic [31:0]      flush_pc
);

  localparam int IDX_W = $clog2(ROB_SZ);

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        is_br;
    logic        pred_taken;
    logic        act_taken;
    logic [31:0] alt_pc;
  } entry_t;

  entry_t             ent_q [ROB_SZ];
  entry_t             ent_d [ROB_SZ];
  logic [IDX_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [TAG_W-1:0]   count_q, count_d;
  logic               commit_valid_q, commit_valid_d;
  logic [4:0]         commit_rd_q, commit_rd_d;
  logic [31:0]        commit_res_q, commit_res_d;
  logic [TAG_W-1:0]   commit_tag_q, commit_tag_d;
  logic               flush_q, flush_d;
  logic [31:0]        flush_pc_q, flush_pc_d;

  logic               do_alloc, do_commit, mispred, cdb_hit;
  logic [IDX_W-1:0]   cdb_idx;

  assign tail_tag     = TAG_W'(tail_q) + TAG_W'(1);
  assign full         = (count_q == TAG_W'(ROB_SZ));
  assign commit_valid = commit_valid_q;
  assign commit_rd    = commit_rd_q;
  assign commit_res   = commit_res_q;
  assign commit_tag   = commit_tag_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  // Tag 0 is "no producer"; otherwise the entry's own value wins over the CDB.
  function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
    logic [IDX_W-1:0] i;
    i = IDX_W'(t - TAG_W'(1));
    if (t == '0)
      return {1'b1, 32'h0};
    if (t <= TAG_W'(ROB_SZ) && ent_q[i].ready)
      return {1'b1, ent_q[i].value};
    if (cdb_valid && cdb_tag == t)
      return {1'b1, cdb_value};
    return '0;
  endfunction

  always_comb begin
    {q1_ready, q1_value} = lookup(q1_tag);
    {q2_ready, q2_value} = lookup(q2_tag);
  end

  assign cdb_idx   = IDX_W'(cdb_tag - TAG_W'(1));
  assign cdb_hit   = cdb_valid && (cdb_tag != '0) && (cdb_tag <= TAG_W'(ROB_SZ));
  assign do_alloc  = rdy && alloc_valid && !full && !flush_q;
  assign do_commit = rdy && !flush_q && ent_q[head_q].busy && ent_q[head_q].ready;
  assign mispred   = do_commit && ent_q[head_q].is_br &&
                     (ent_q[head_q].act_taken != ent_q[head_q].pred_taken);

  always_comb begin
    ent_d          = ent_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_rd_d    = commit_rd_q;
    commit_res_d   = commit_res_q;
    commit_tag_d   = commit_tag_q;
    flush_d        = 1'b0;
    flush_pc_d     = flush_pc_q;

    if (rdy) begin
      if (cdb_hit && ent_q[cdb_idx].busy) begin
        ent_d[cdb_idx].ready     = 1'b1;
        ent_d[cdb_idx].value     = cdb_value;
        ent_d[cdb_idx].act_taken = cdb_br_taken;
      end

      if (do_alloc) begin
        ent_d[tail_q].busy       = 1'b1;
        ent_d[tail_q].ready      = 1'b0;
        ent_d[tail_q].has_rd     = alloc_has_rd;
        ent_d[tail_q].rd         = alloc_rd;
        ent_d[tail_q].value      = '0;
        ent_d[tail_q].is_br      = alloc_is_br;
        ent_d[tail_q].pred_taken = alloc_pred_taken;
        ent_d[tail_q].act_taken  = 1'b0;
        ent_d[tail_q].alt_pc     = alloc_alt_pc;
        tail_d                   = tail_q + 1'b1;
      end

      if (do_commit) begin
        commit_valid_d = 1'b1;
        commit_rd_d    = ent_q[head_q].has_rd ? ent_q[head_q].rd : 5'd0;
        commit_res_d   = ent_q[head_q].value;
        commit_tag_d   = TAG_W'(head_q) + TAG_W'(1);
        ent_d[head_q]  = '0;
        head_d         = head_q + 1'b1;
      end

      count_d = count_q + TAG_W'(do_alloc) - TAG_W'(do_commit);

      // A wrong-path branch retiring discards everything younger, including
      // whatever allocation or CDB write lands on this same edge.
      if (mispred) begin
        flush_d    = 1'b1;
        flush_pc_d = ent_q[head_q].alt_pc;
        for (int i = 0; i < ROB_SZ; i++) ent_d[i] = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_SZ; i++) ent_q[i] <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_rd_q    <= '0;
      commit_res_q   <= '0;
      commit_tag_q   <= '0;
      flush_q        <= 1'b0;
      flush_pc_q     <= '0;
    end else begin
      for (int i = 0; i < ROB_SZ; i++) ent_q[i] <= ent_d[i];
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_rd_q    <= commit_rd_d;
      commit_res_q   <= commit_res_d;
      commit_tag_q   <= commit_tag_d;
      flush_q        <= flush_d;
      flush_pc_q     <= flush_pc_d;
    end
  end

endmodule
